data_mem_responder: RTL and testbench

- Data-side responder for the single-cycle ARMv4 core. It serves the core's data bus (MemWrite, address, WriteData, ReadData).
- Provides a word RAM plus a small MMIO window. The window contains a free-running cycle timer and an 8-bit output FIFO drained by an external valid/ready consumer (LED/UART stub).
- The core reads combinationally within its single cycle. Writes commit on the rising edge.

---
 rtl/data_mem_responder.sv | 116 +++++++++++
 tb/tb_data_mem_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-side responder for the single-cycle core: word RAM plus an MMIO window
// holding a free-running timer, a TX byte FIFO and its status register.
module data_mem_responder #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready
);

  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Byte-lane bits of the address carry no meaning on this word bus.
  logic unused_addr;
  assign unused_addr = ^Addr[1:0];

  logic ram_hit, mmio_hit, timer_hit, tx_hit, stat_hit;
  logic [RAM_AW-1:0] ram_idx;

  always_comb begin
    ram_hit   = (Addr[31:10] == 22'd0);
    mmio_hit  = (Addr[31:8] == 24'h000004);
    timer_hit = mmio_hit && (Addr[7:2] == 6'd0);
    tx_hit    = mmio_hit && (Addr[7:2] == 6'd1);
    stat_hit  = mmio_hit && (Addr[7:2] == 6'd2);
    ram_idx   = Addr[RAM_AW+1:2];
  end

  // RAM contents survive reset, so this array has no reset branch.
  logic [31:0] mem_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (MemWrite && ram_hit) mem_q[ram_idx] <= WriteData;
  end

  logic [31:0]      timer_q, timer_d;
  logic [7:0]       buf_q [FIFO_DEPTH];
  logic [7:0]       buf_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             pop, push_req, push_ok;

  always_comb begin
    out_valid = (count_q != '0);
    out_data  = buf_q[rd_ptr_q];
    pop       = out_valid && out_ready;
    push_req  = MemWrite && tx_hit;
    // A full FIFO still takes a push when the consumer frees a slot this edge.
    push_ok   = push_req && ((count_q < DEPTH_C) || pop);
  end

  always_comb begin
    timer_d  = (MemWrite && timer_hit) ? WriteData : timer_q + 32'd1;
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      buf_d[wr_ptr_q] = WriteData[7:0];
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (MemWrite && stat_hit && WriteData[2]) ovf_d = 1'b0;
    if (push_req && !push_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) buf_q[i] <= 8'h00;
    end else begin
      timer_q  <= timer_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      buf_q    <= buf_d;
    end
  end

  logic [31:0] status;

  always_comb begin
    status            = '0;
    status[0]         = (count_q == '0);
    status[1]         = (count_q == DEPTH_C);
    status[2]         = ovf_q;
    status[8 +: CNT_W] = count_q;
    ReadData          = 32'h0;
    if (ram_hit)        ReadData = mem_q[ram_idx];
    else if (timer_hit) ReadData = timer_q;
    else if (stat_hit)  ReadData = status;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a queue/array reference model tracks RAM,
// timer and FIFO state; each scenario task compares DUT outputs against it.
module tb_data_mem_responder;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  int n_checks;
  int n_fail;

  always #5 clk = ~clk;

  data_mem_responder #(.RAM_WORDS(256), .FIFO_DEPTH(DEPTH), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .MemWrite(MemWrite), .Addr(Addr), .WriteData(WriteData),
    .ReadData(ReadData), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  // Reference model state
  logic [7:0]  mq[$];
  logic [31:0] m_timer;
  bit          m_ovf;
  logic [31:0] m_ram [int];

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'(mq.size()) << 8;
    s[0] = (mq.size() == 0);
    s[1] = (mq.size() == DEPTH);
    s[2] = m_ovf;
    return s;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (w < 32'h400) return m_ram.exists(int'(w >> 2)) ? m_ram[int'(w >> 2)] : 32'h0;
    if (w == 32'h400) return m_timer;
    if (w == 32'h408) return m_status();
    return 32'h0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_timer = 32'h0;
    m_ovf   = 1'b0;
  endtask

  // One clock: capture inputs, let the edge happen, apply the same rules to the model.
  task automatic cycle();
    logic [31:0] w, d;
    bit pop, push, we;
    w    = Addr & ~32'h3;
    d    = WriteData;
    we   = MemWrite;
    pop  = (mq.size() != 0) && out_ready;
    push = we && (w == 32'h404);
    @(posedge clk);
    if (!rst) begin
      m_timer = (we && w == 32'h400) ? d : m_timer + 32'd1;
      if (we && w < 32'h400) m_ram[int'(w >> 2)] = d;
      if (we && w == 32'h408 && d[2]) m_ovf = 1'b0;
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(d[7:0]);
        else m_ovf = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; Addr = a; WriteData = d;
    cycle();
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    MemWrite = 1'b0; Addr = a;
    #1;
  endtask

  task automatic test_reset();
    rd(32'h408);
    n_checks++; if (ReadData !== 32'h1) begin n_fail++; $display("FAIL reset_status got %h exp %h", ReadData, 32'h1); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", out_data); end
    rd(32'h400);
    n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL reset_timer got %h exp 0", ReadData); end
  endtask

  task automatic test_timer();
    repeat (10) cycle();
    rd(32'h400);
    n_checks++; if (ReadData !== 32'd10) begin n_fail++; $display("FAIL timer_10 got %h exp %h", ReadData, 32'd10); end
    wr(32'h400, 32'hFFFF_FFFE);
    rd(32'h400);
    n_checks++; if (ReadData !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL timer_load got %h exp fffffffe", ReadData); end
    cycle();
    n_checks++; if (ReadData !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL timer_max got %h exp ffffffff", ReadData); end
    cycle();
    n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL timer_wrap got %h exp 0", ReadData); end
    repeat (5) cycle();
    Addr = 32'h400;
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL timer_async_rst got %h exp 0", ReadData); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle();
    rd(32'h400);
    n_checks++; if (ReadData !== 32'd3) begin n_fail++; $display("FAIL timer_after_rst got %h exp 3", ReadData); end
  endtask

  task automatic test_ram();
    logic [31:0] addrs [8];
    wr(32'h000, 32'hA5A5_0000);
    wr(32'h010, 32'hDEAD_BEEF);
    wr(32'h3FC, 32'h1234_5678);
    rd(32'h010);
    n_checks++; if (ReadData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_010 got %h exp deadbeef", ReadData); end
    rd(32'h3FC);
    n_checks++; if (ReadData !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_3fc got %h exp 12345678", ReadData); end
    rd(32'h800);
    n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd got %h exp 0", ReadData); end
    wr(32'h800, 32'hFFFF_0000);
    rd(32'h000);
    n_checks++; if (ReadData !== 32'hA5A5_0000) begin n_fail++; $display("FAIL no_alias got %h exp a5a50000", ReadData); end
    // Same-cycle read of the word being written shows the old contents
    MemWrite = 1'b1; Addr = 32'h010; WriteData = 32'hCAFE_F00D;
    #1;
    n_checks++; if (ReadData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rdw_old got %h exp deadbeef", ReadData); end
    cycle();
    rd(32'h010);
    n_checks++; if (ReadData !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rdw_new got %h exp cafef00d", ReadData); end
    rd(32'h40C);
    n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL mmio_hole got %h exp 0", ReadData); end
    rd(32'h404);
    n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL txdata_rd got %h exp 0", ReadData); end
    for (int i = 0; i < 8; i++) begin
      addrs[i] = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      wr(addrs[i], $urandom);
    end
    for (int i = 0; i < 8; i++) begin
      rd(addrs[i] | 32'($urandom_range(0, 3)));
      n_checks++; if (ReadData !== exp_read(addrs[i])) begin n_fail++; $display("FAIL ram_rand[%0d] got %h exp %h", i, ReadData, exp_read(addrs[i])); end
      cycle();
    end
  endtask

  task automatic test_fifo_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(32'h404, 32'h41 + 32'(i));
    rd(32'h408);
    n_checks++; if (ReadData !== 32'h0000_0802) begin n_fail++; $display("FAIL fill_status got %h exp 00000802", ReadData); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin n_fail++; $display("FAIL fill_head got %b/%h exp 1/41", out_valid, out_data); end
    wr(32'h404, 32'h49);
    rd(32'h408);
    n_checks++; if (ReadData !== 32'h0000_0806) begin n_fail++; $display("FAIL ovf_set got %h exp 00000806", ReadData); end
    wr(32'h408, 32'h4);
    rd(32'h408);
    n_checks++; if (ReadData !== 32'h0000_0802) begin n_fail++; $display("FAIL ovf_clear got %h exp 00000802", ReadData); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'(8'h41 + i)) begin n_fail++; $display("FAIL drain[%0d] got %b/%h exp 1/%h", i, out_valid, out_data, 8'(8'h41 + i)); end
      cycle();
    end
    rd(32'h408);
    n_checks++; if (out_valid !== 1'b0 || ReadData !== 32'h1) begin n_fail++; $display("FAIL drained got %b/%h exp 0/00000001", out_valid, ReadData); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_pushpop();
    logic [7:0] exp_seq [8];
    logic [7:0] first [8];
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      first[i] = 8'($urandom);
      wr(32'h404, {24'd0, first[i]});
    end
    for (int i = 0; i < 7; i++) exp_seq[i] = first[i + 1];
    exp_seq[7] = 8'h55;
    out_ready = 1'b1;
    wr(32'h404, 32'h55);
    out_ready = 1'b0;
    rd(32'h408);
    n_checks++; if (ReadData !== 32'h0000_0802) begin n_fail++; $display("FAIL full_pushpop_status got %h exp 00000802", ReadData); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin n_fail++; $display("FAIL pushpop_order[%0d] got %b/%h exp 1/%h", i, out_valid, out_data, exp_seq[i]); end
      cycle();
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pushpop_empty got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int pushed = 0;
    int cyc = 0;
    bit hold = 1'b0;
    logic [7:0] prev = 8'h00;
    while ((pushed < 100 || mq.size() != 0) && cyc < 3000) begin
      out_ready = ($urandom_range(0, 99) < 55);
      if (pushed < 100 && mq.size() < DEPTH && $urandom_range(0, 3) != 0) begin
        MemWrite = 1'b1; Addr = 32'h404; WriteData = $urandom; pushed++;
      end else begin
        MemWrite = 1'b0; Addr = 32'h400;
      end
      #1;
      n_checks++; if (out_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL bp_valid cyc %0d got %b exp %b", cyc, out_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        n_checks++; if (out_data !== mq[0]) begin n_fail++; $display("FAIL bp_order cyc %0d got %h exp %h", cyc, out_data, mq[0]); end
      end
      if (hold) begin
        n_checks++; if (out_data !== prev) begin n_fail++; $display("FAIL bp_stable cyc %0d got %h exp %h", cyc, out_data, prev); end
      end
      hold = (mq.size() != 0) && !out_ready;
      prev = out_data;
      cycle();
      cyc++;
    end
    MemWrite = 1'b0; out_ready = 1'b0;
    n_checks++; if (pushed != 100 || mq.size() != 0) begin n_fail++; $display("FAIL bp_timeout pushed %0d left %0d exp 100/0", pushed, mq.size()); end
    rd(32'h408);
    n_checks++; if (ReadData !== 32'h1) begin n_fail++; $display("FAIL bp_final_status got %h exp 00000001", ReadData); end
  endtask

  task automatic test_reset_mid_drain();
    wr(32'h020, 32'h0BAD_F00D);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(32'h404, 32'h60 + 32'(i));
    rd(32'h408);
    n_checks++; if (ReadData !== 32'h0000_0300) begin n_fail++; $display("FAIL pre_rst_status got %h exp 00000300", ReadData); end
    out_ready = 1'b1;
    #1 rst = 1'b1;
    model_reset();
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin n_fail++; $display("FAIL rst_fifo got %b/%h exp 0/00", out_valid, out_data); end
    n_checks++; if (ReadData !== 32'h1) begin n_fail++; $display("FAIL rst_status got %h exp 00000001", ReadData); end
    Addr = 32'h020;
    #1;
    n_checks++; if (ReadData !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rst_ram_keep got %h exp 0badf00d", ReadData); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    wr(32'h404, 32'h77);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h77) begin n_fail++; $display("FAIL post_rst_push got %b/%h exp 1/77", out_valid, out_data); end
    rd(32'h408);
    n_checks++; if (ReadData !== m_status()) begin n_fail++; $display("FAIL post_rst_status got %h exp %h", ReadData, m_status()); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; MemWrite = 1'b0; Addr = 32'h0; WriteData = 32'h0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_timer();
    test_ram();
    test_fifo_fill();
    test_full_pushpop();
    test_backpressure();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
